// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
// Shared widths, issue type codes and the branch mispredict rule for the
// reorder buffer. Imported by the interface, the top and the operand lookup.
// Optional feature macro used elsewhere in this slice: ROB_PERF_CNT_EN.
package reorder_buffer_pkg;

   localparam int ROB_WIDTH  = 4;
   localparam int ROB_SIZE   = 2 ** ROB_WIDTH;
   localparam int REG_WIDTH  = 5;
   localparam int DATA_WIDTH = 32;

   // Kind of instruction held by an entry; decides which pulse it raises at retire.
   typedef enum logic [1:0] {
      ROB_REG    = 2'd0,
      ROB_STORE  = 2'd1,
      ROB_BRANCH = 2'd2
   } robType_t;

   // A branch's resolved direction lives in bit 0 of its result value.
   function automatic logic isMispredict(input logic resolvedTaken, input logic predTaken);
      return resolvedTaken != predTaken;
   endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if
// Bundles the issue, query, writeback and commit signals of the reorder buffer.
// The pipeline side uses the master modport, the buffer itself the slave one.
// With ROB_PERF_CNT_EN defined the two performance counters are carried too.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic                  issueFlag;
   logic [1:0]            issueType;
   logic [REG_WIDTH-1:0]  issueRd;
   logic                  issueReady;
   logic [DATA_WIDTH-1:0] issueVal;
   logic                  issuePredTaken;
   logic [DATA_WIDTH-1:0] issueAltPc;
   logic [ROB_WIDTH-1:0]  allocTag;
   logic                  full;

   logic [ROB_WIDTH-1:0]  queryJTag;
   logic [ROB_WIDTH-1:0]  queryKTag;
   logic                  queryJReady;
   logic                  queryKReady;
   logic [DATA_WIDTH-1:0] queryJVal;
   logic [DATA_WIDTH-1:0] queryKVal;

   logic                  aluFlag;
   logic [DATA_WIDTH-1:0] aluVal;
   logic [ROB_WIDTH-1:0]  aluDest;
   logic                  lsbFlag;
   logic [DATA_WIDTH-1:0] lsbVal;
   logic [ROB_WIDTH-1:0]  lsbDest;

   logic                  commitFlag;
   logic [REG_WIDTH-1:0]  commitRd;
   logic [DATA_WIDTH-1:0] commitVal;
   logic [ROB_WIDTH-1:0]  commitTag;
   logic                  storeCommitFlag;
   logic                  clearOut;
   logic [DATA_WIDTH-1:0] clearPc;
`ifdef ROB_PERF_CNT_EN
   logic [31:0]           perfRetireCnt;
   logic [31:0]           perfFlushCnt;
`endif

   modport master (
      output issueFlag, issueType, issueRd, issueReady, issueVal, issuePredTaken, issueAltPc,
      output queryJTag, queryKTag,
      output aluFlag, aluVal, aluDest, lsbFlag, lsbVal, lsbDest,
      input  allocTag, full, queryJReady, queryKReady, queryJVal, queryKVal,
      input  commitFlag, commitRd, commitVal, commitTag, storeCommitFlag, clearOut, clearPc
`ifdef ROB_PERF_CNT_EN
      , input perfRetireCnt, perfFlushCnt
`endif
   );

   modport slave (
      input  issueFlag, issueType, issueRd, issueReady, issueVal, issuePredTaken, issueAltPc,
      input  queryJTag, queryKTag,
      input  aluFlag, aluVal, aluDest, lsbFlag, lsbVal, lsbDest,
      output allocTag, full, queryJReady, queryKReady, queryJVal, queryKVal,
      output commitFlag, commitRd, commitVal, commitTag, storeCommitFlag, clearOut, clearPc
`ifdef ROB_PERF_CNT_EN
      , output perfRetireCnt, perfFlushCnt
`endif
   );

endinterface

// File: rtl/reorder_buffer_operand_lookup.sv
// rob_operand_lookup
// Resolves one dispatch operand tag: the value stored in the buffer, or a
// result being broadcast this very cycle so dispatch does not wait an extra
// cycle. Freed entries report their stored bits with no bypass.
module rob_operand_lookup
   import reorder_buffer_pkg::*;
(
   input  logic [ROB_WIDTH-1:0]  i_tag,
   input  logic                  i_busy,
   input  logic                  i_storedReady,
   input  logic [DATA_WIDTH-1:0] i_storedVal,
   input  logic                  i_aluFlag,
   input  logic [ROB_WIDTH-1:0]  i_aluDest,
   input  logic [DATA_WIDTH-1:0] i_aluVal,
   input  logic                  i_lsbFlag,
   input  logic [ROB_WIDTH-1:0]  i_lsbDest,
   input  logic [DATA_WIDTH-1:0] i_lsbVal,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_val
);

   logic w_aluHit;
   logic w_lsbHit;

   assign w_aluHit = i_busy && i_aluFlag && (i_aluDest == i_tag);
   assign w_lsbHit = i_busy && i_lsbFlag && (i_lsbDest == i_tag);

   // Stored state by default; a matching broadcast overrides it, LSB ahead of ALU.
   always_comb begin
      o_ready = i_storedReady;
      o_val   = i_storedVal;
      if (w_lsbHit) begin
         o_ready = 1'b1;
         o_val   = i_lsbVal;
      end else if (w_aluHit) begin
         o_ready = 1'b1;
         o_val   = i_aluVal;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer
// Circular in-order reorder buffer: allocates tags at the tail, captures ALU
// and LSB results, answers operand queries and retires one entry per cycle
// from the head. A mispredicted branch at retire flushes everything.
// Define ROB_PERF_CNT_EN to add the retire/flush performance counters.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic            clockIn,
   input  logic            resetIn,
   input  logic            readyIn,
   reorder_buffer_if.slave robBus
);

   localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH+1)'(ROB_SIZE);

   logic [ROB_WIDTH-1:0]  r_head;
   logic [ROB_WIDTH-1:0]  r_tail;
   logic [ROB_WIDTH:0]    r_count;
   logic [ROB_SIZE-1:0]   r_busy;
   logic [ROB_SIZE-1:0]   r_ready;
   logic [ROB_SIZE-1:0]   r_predTaken;
   robType_t              r_type  [ROB_SIZE];
   logic [REG_WIDTH-1:0]  r_rd    [ROB_SIZE];
   logic [DATA_WIDTH-1:0] r_val   [ROB_SIZE];
   logic [DATA_WIDTH-1:0] r_altPc [ROB_SIZE];

   logic                  r_commitFlag;
   logic [REG_WIDTH-1:0]  r_commitRd;
   logic [DATA_WIDTH-1:0] r_commitVal;
   logic [ROB_WIDTH-1:0]  r_commitTag;
   logic                  r_storeCommitFlag;
   logic                  r_clearOut;
   logic [DATA_WIDTH-1:0] r_clearPc;

   logic w_full;
   logic w_retire;
   logic w_mispredict;
   logic w_issue;
   logic w_wbEnable;
   logic w_aluWrite;
   logic w_lsbWrite;

   assign w_full       = (r_count == FULL_COUNT);
   assign w_retire     = r_busy[r_head] && r_ready[r_head];
   assign w_mispredict = w_retire && (r_type[r_head] == ROB_BRANCH) &&
                         isMispredict(r_val[r_head][0], r_predTaken[r_head]);
   assign w_issue      = robBus.issueFlag && !w_full && !w_mispredict;
   assign w_wbEnable   = !r_clearOut;
   assign w_aluWrite   = robBus.aluFlag && w_wbEnable && r_busy[robBus.aluDest];
   assign w_lsbWrite   = robBus.lsbFlag && w_wbEnable && r_busy[robBus.lsbDest];

   // Entry storage: free on retire, capture broadcasts, fill the tail on issue; a flush drops all entries.
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         r_busy      <= '0;
         r_ready     <= '0;
         r_predTaken <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            r_type[i]  <= ROB_REG;
            r_rd[i]    <= '0;
            r_val[i]   <= '0;
            r_altPc[i] <= '0;
         end
      end else if (readyIn) begin
         if (w_mispredict) begin
            r_busy <= '0;
         end else begin
            if (w_retire) begin
               r_busy[r_head] <= 1'b0;
            end
            if (w_aluWrite) begin
               r_ready[robBus.aluDest] <= 1'b1;
               r_val[robBus.aluDest]   <= robBus.aluVal;
            end
            if (w_lsbWrite) begin
               r_ready[robBus.lsbDest] <= 1'b1;
               r_val[robBus.lsbDest]   <= robBus.lsbVal;
            end
            if (w_issue) begin
               r_busy[r_tail]      <= 1'b1;
               r_ready[r_tail]     <= robBus.issueReady;
               r_val[r_tail]       <= robBus.issueVal;
               r_type[r_tail]      <= robType_t'(robBus.issueType);
               r_rd[r_tail]        <= robBus.issueRd;
               r_predTaken[r_tail] <= robBus.issuePredTaken;
               r_altPc[r_tail]     <= robBus.issueAltPc;
            end
         end
      end
   end

   // Head/tail pointers wrap naturally; count tracks occupancy so full and empty never alias.
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (readyIn) begin
         if (w_mispredict) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_retire) begin
               r_head <= r_head + 1'b1;
            end
            if (w_issue) begin
               r_tail <= r_tail + 1'b1;
            end
            case ({w_issue, w_retire})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Commit side is registered one cycle after the retire decision; data fields hold between retires.
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         r_commitFlag      <= 1'b0;
         r_commitRd        <= '0;
         r_commitVal       <= '0;
         r_commitTag       <= '0;
         r_storeCommitFlag <= 1'b0;
         r_clearOut        <= 1'b0;
         r_clearPc         <= '0;
      end else if (readyIn) begin
         r_commitFlag      <= w_retire && (r_type[r_head] == ROB_REG) && (r_rd[r_head] != '0);
         r_storeCommitFlag <= w_retire && (r_type[r_head] == ROB_STORE);
         r_clearOut        <= w_mispredict;
         if (w_retire) begin
            r_commitRd  <= r_rd[r_head];
            r_commitVal <= r_val[r_head];
            r_commitTag <= r_head;
         end
         if (w_mispredict) begin
            r_clearPc <= r_altPc[r_head];
         end
      end
   end

`ifdef ROB_PERF_CNT_EN
   logic [31:0] r_perfRetireCnt;
   logic [31:0] r_perfFlushCnt;

   // Free-running event counters; they wrap silently at 2^32.
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         r_perfRetireCnt <= '0;
         r_perfFlushCnt  <= '0;
      end else if (readyIn) begin
         if (w_retire) begin
            r_perfRetireCnt <= r_perfRetireCnt + 1'b1;
         end
         if (w_mispredict) begin
            r_perfFlushCnt <= r_perfFlushCnt + 1'b1;
         end
      end
   end

   assign robBus.perfRetireCnt = r_perfRetireCnt;
   assign robBus.perfFlushCnt  = r_perfFlushCnt;
`endif

   rob_operand_lookup u_lookupJ (
      .i_tag         (robBus.queryJTag),
      .i_busy        (r_busy[robBus.queryJTag]),
      .i_storedReady (r_ready[robBus.queryJTag]),
      .i_storedVal   (r_val[robBus.queryJTag]),
      .i_aluFlag     (robBus.aluFlag && w_wbEnable),
      .i_aluDest     (robBus.aluDest),
      .i_aluVal      (robBus.aluVal),
      .i_lsbFlag     (robBus.lsbFlag && w_wbEnable),
      .i_lsbDest     (robBus.lsbDest),
      .i_lsbVal      (robBus.lsbVal),
      .o_ready       (robBus.queryJReady),
      .o_val         (robBus.queryJVal)
   );

   rob_operand_lookup u_lookupK (
      .i_tag         (robBus.queryKTag),
      .i_busy        (r_busy[robBus.queryKTag]),
      .i_storedReady (r_ready[robBus.queryKTag]),
      .i_storedVal   (r_val[robBus.queryKTag]),
      .i_aluFlag     (robBus.aluFlag && w_wbEnable),
      .i_aluDest     (robBus.aluDest),
      .i_aluVal      (robBus.aluVal),
      .i_lsbFlag     (robBus.lsbFlag && w_wbEnable),
      .i_lsbDest     (robBus.lsbDest),
      .i_lsbVal      (robBus.lsbVal),
      .o_ready       (robBus.queryKReady),
      .o_val         (robBus.queryKVal)
   );

   assign robBus.allocTag        = r_tail;
   assign robBus.full            = w_full;
   assign robBus.commitFlag      = r_commitFlag;
   assign robBus.commitRd        = r_commitRd;
   assign robBus.commitVal       = r_commitVal;
   assign robBus.commitTag       = r_commitTag;
   assign robBus.storeCommitFlag = r_storeCommitFlag;
   assign robBus.clearOut        = r_clearOut;
   assign robBus.clearPc         = r_clearPc;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
// Directed scenarios followed by a random run, all checked against a
// program-order queue model of the reorder buffer. Checks the perf counters
// as well when ROB_PERF_CNT_EN is defined.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic clockIn = 1'b0;
   logic resetIn;
   logic readyIn;

   reorder_buffer_if robBus();

   reorder_buffer dut (
      .clockIn (clockIn),
      .resetIn (resetIn),
      .readyIn (readyIn),
      .robBus  (robBus)
   );

   always #5 clockIn = ~clockIn;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0]  tag;
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic        ready;
      logic [31:0] val;
      logic        pred;
      logic [31:0] altPc;
   } entry_t;

   typedef struct {
      logic        readyIn;
      logic        issueFlag;
      logic [1:0]  issueType;
      logic [4:0]  issueRd;
      logic        issueReady;
      logic [31:0] issueVal;
      logic        issuePredTaken;
      logic [31:0] issueAltPc;
      logic [3:0]  queryJTag;
      logic [3:0]  queryKTag;
      logic        aluFlag;
      logic [31:0] aluVal;
      logic [3:0]  aluDest;
      logic        lsbFlag;
      logic [31:0] lsbVal;
      logic [3:0]  lsbDest;
   } stim_t;

   // Reference model: entries in program order, oldest at the front.
   entry_t      rob[$];
   int          mTail;
   logic        eCommitFlag, eStoreFlag, eClearOut;
   logic [4:0]  eCommitRd;
   logic [31:0] eCommitVal, eClearPc;
   logic [3:0]  eCommitTag;
   logic [31:0] ePerfRetire, ePerfFlush;
   stim_t       s;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      rob.delete();
      mTail = 0;
      eCommitFlag = 0; eStoreFlag = 0; eClearOut = 0;
      eCommitRd = '0; eCommitVal = '0; eCommitTag = '0; eClearPc = '0;
      ePerfRetire = '0; ePerfFlush = '0;
   endtask

   function automatic int findIdx(input logic [3:0] tag);
      foreach (rob[i]) if (rob[i].tag == tag) return i;
      return -1;
   endfunction

   // One clock edge of the model for stimulus s.
   task automatic modelEdge();
      bit wasFull, flush, newCommit, newStore;
      int idx;
      entry_t e;
      if (!s.readyIn) return;
      wasFull = (rob.size() == ROB_SIZE);
      flush = 0; newCommit = 0; newStore = 0;
      if (rob.size() > 0 && rob[0].ready) begin
         e = rob.pop_front();
         eCommitRd = e.rd; eCommitVal = e.val; eCommitTag = e.tag;
         ePerfRetire++;
         if (e.kind == ROB_REG) newCommit = (e.rd != 0);
         else if (e.kind == ROB_STORE) newStore = 1;
         else if (e.kind == ROB_BRANCH && e.val[0] != e.pred) begin
            flush = 1;
            eClearPc = e.altPc;
            rob.delete();
            mTail = 0;
            ePerfFlush++;
         end
      end
      if (!flush) begin
         if (!eClearOut) begin
            idx = findIdx(s.aluDest);
            if (s.aluFlag && idx >= 0) begin rob[idx].ready = 1; rob[idx].val = s.aluVal; end
            idx = findIdx(s.lsbDest);
            if (s.lsbFlag && idx >= 0) begin rob[idx].ready = 1; rob[idx].val = s.lsbVal; end
         end
         if (s.issueFlag && !wasFull) begin
            e.tag = 4'(mTail); e.kind = s.issueType; e.rd = s.issueRd; e.ready = s.issueReady;
            e.val = s.issueVal; e.pred = s.issuePredTaken; e.altPc = s.issueAltPc;
            rob.push_back(e);
            mTail = (mTail + 1) % ROB_SIZE;
         end
      end
      eCommitFlag = newCommit;
      eStoreFlag  = newStore;
      eClearOut   = flush;
   endtask

   task automatic checkQuery(input string tag, input logic [3:0] qTag, input logic obsReady, input logic [31:0] obsVal);
      int idx;
      logic expReady;
      logic [31:0] expVal;
      idx = findIdx(qTag);
      if (idx >= 0) begin
         expReady = rob[idx].ready;
         expVal   = rob[idx].val;
         if (!eClearOut) begin
            if (s.aluFlag && s.aluDest == qTag) begin expReady = 1; expVal = s.aluVal; end
            if (s.lsbFlag && s.lsbDest == qTag) begin expReady = 1; expVal = s.lsbVal; end
         end
         check({tag, " ready"}, 32'(obsReady), 32'(expReady));
         check({tag, " val"}, obsVal, expVal);
      end
   endtask

   task automatic checkOutput();
      check("commitFlag", 32'(robBus.commitFlag), 32'(eCommitFlag));
      check("commitRd", 32'(robBus.commitRd), 32'(eCommitRd));
      check("commitVal", robBus.commitVal, eCommitVal);
      check("commitTag", 32'(robBus.commitTag), 32'(eCommitTag));
      check("storeCommitFlag", 32'(robBus.storeCommitFlag), 32'(eStoreFlag));
      check("clearOut", 32'(robBus.clearOut), 32'(eClearOut));
      check("clearPc", robBus.clearPc, eClearPc);
`ifdef ROB_PERF_CNT_EN
      check("perfRetireCnt", robBus.perfRetireCnt, ePerfRetire);
      check("perfFlushCnt", robBus.perfFlushCnt, ePerfFlush);
`endif
   endtask

   task automatic idle();
      s = '{default: '0};
      s.readyIn = 1'b1;
   endtask

   task automatic drive();
      readyIn               = s.readyIn;
      robBus.issueFlag      = s.issueFlag;
      robBus.issueType      = s.issueType;
      robBus.issueRd        = s.issueRd;
      robBus.issueReady     = s.issueReady;
      robBus.issueVal       = s.issueVal;
      robBus.issuePredTaken = s.issuePredTaken;
      robBus.issueAltPc     = s.issueAltPc;
      robBus.queryJTag      = s.queryJTag;
      robBus.queryKTag      = s.queryKTag;
      robBus.aluFlag        = s.aluFlag;
      robBus.aluVal         = s.aluVal;
      robBus.aluDest        = s.aluDest;
      robBus.lsbFlag        = s.lsbFlag;
      robBus.lsbVal         = s.lsbVal;
      robBus.lsbDest        = s.lsbDest;
   endtask

   // One cycle: check registered outputs, drive s, check combinational outputs, advance the model.
   task automatic applyStimulus();
      @(negedge clockIn);
      checkOutput();
      drive();
      #1;
      check("allocTag", 32'(robBus.allocTag), 32'(mTail));
      check("full", 32'(robBus.full), 32'(rob.size() == ROB_SIZE));
      checkQuery("queryJ", s.queryJTag, robBus.queryJReady, robBus.queryJVal);
      checkQuery("queryK", s.queryKTag, robBus.queryKReady, robBus.queryKVal);
      modelEdge();
   endtask

   task automatic settle();
      @(posedge clockIn);
      #1;
   endtask

   task automatic issueOne(input logic [1:0] kind, input logic [4:0] rd, input logic rdy,
                           input logic [31:0] val, input logic pred, input logic [31:0] altPc);
      idle();
      s.issueFlag = 1; s.issueType = kind; s.issueRd = rd; s.issueReady = rdy;
      s.issueVal = val; s.issuePredTaken = pred; s.issueAltPc = altPc;
      applyStimulus();
   endtask

   task automatic applyReset();
      @(negedge clockIn);
      resetIn = 1'b0;
      idle();
      drive();
      #2;
      check("rst commitFlag", 32'(robBus.commitFlag), 32'd0);
      check("rst storeCommitFlag", 32'(robBus.storeCommitFlag), 32'd0);
      check("rst clearOut", 32'(robBus.clearOut), 32'd0);
      check("rst clearPc", robBus.clearPc, 32'd0);
      check("rst commitVal", robBus.commitVal, 32'd0);
      check("rst allocTag", 32'(robBus.allocTag), 32'd0);
      check("rst full", 32'(robBus.full), 32'd0);
      modelReset();
      @(negedge clockIn);
      resetIn = 1'b1;
   endtask

   // Write back the oldest unfinished entry each cycle until the model is empty (bounded).
   task automatic drain();
      for (int k = 0; k < 60 && rob.size() > 0; k++) begin
         idle();
         foreach (rob[i]) begin
            if (!rob[i].ready && !s.aluFlag) begin
               s.aluFlag = 1; s.aluDest = rob[i].tag; s.aluVal = $urandom;
            end
         end
         applyStimulus();
      end
   endtask

   initial begin
      logic [3:0] brTag;
      int         tailSave;
      resetIn = 1'b0;
      idle();
      drive();
      modelReset();
      repeat (2) @(negedge clockIn);
      applyReset();

      // Scenario 1: three REG issues, first result commits two cycles after its writeback.
      for (int i = 0; i < 3; i++) begin
         issueOne(ROB_REG, 5'(i + 1), 0, 0, 0, 0);
         check("t1 allocTag", 32'(robBus.allocTag), 32'(i));
      end
      idle(); s.aluFlag = 1; s.aluDest = 0; s.aluVal = 5; applyStimulus();
      idle(); applyStimulus();
      settle();
      check("t1 commitFlag", 32'(robBus.commitFlag), 32'd1);
      check("t1 commitRd", 32'(robBus.commitRd), 32'd1);
      check("t1 commitVal", robBus.commitVal, 32'd5);

      // Scenario 2: writebacks in reverse order still commit in program order.
      issueOne(ROB_REG, 5'd4, 0, 0, 0, 0);
      idle(); s.lsbFlag = 1; s.lsbDest = 3; s.lsbVal = 32'h33; applyStimulus();
      idle(); s.aluFlag = 1; s.aluDest = 2; s.aluVal = 32'h22; applyStimulus();
      idle(); s.aluFlag = 1; s.aluDest = 1; s.aluVal = 32'h11; applyStimulus();
      settle();
      for (int i = 0; i < 3; i++) begin
         idle(); applyStimulus();
         settle();
         check("t2 commitTag", 32'(robBus.commitTag), 32'(i + 1));
         check("t2 commitVal", robBus.commitVal, 32'((i + 1) * 32'h11));
      end

      // Scenario 3: fill from tag 4 across the wrap, overflow issue ignored, full/empty boundary.
      for (int i = 0; i < 16; i++) begin
         issueOne(ROB_REG, 5'(i + 1), 0, $urandom, 0, 0);
         check("t3 allocTag", 32'(robBus.allocTag), 32'((4 + i) % 16));
      end
      issueOne(ROB_REG, 5'd9, 1, 32'hDEAD, 0, 0);
      check("t3 full", 32'(robBus.full), 32'd1);
      settle();
      check("t3 allocTag after overflow", 32'(robBus.allocTag), 32'd4);
      idle(); s.aluFlag = 1; s.aluDest = 4; s.aluVal = 32'hA4;
      s.lsbFlag = 1; s.lsbDest = 5; s.lsbVal = 32'hA5; applyStimulus();
      issueOne(ROB_REG, 5'd7, 0, 0, 0, 0);
      settle();
      check("t3 full after retire", 32'(robBus.full), 32'd0);
      check("t3 commitTag", 32'(robBus.commitTag), 32'd4);
      issueOne(ROB_REG, 5'd8, 0, 0, 0, 0);
      settle();
      check("t3 full issue+retire", 32'(robBus.full), 32'd0);
      check("t3 allocTag issue+retire", 32'(robBus.allocTag), 32'd5);
      issueOne(ROB_REG, 5'd9, 0, 0, 0, 0);
      settle();
      check("t3 full again", 32'(robBus.full), 32'd1);
      drain();

      // Scenario 4: mispredicted branch flushes; a late writeback is ignored.
      brTag = 4'(mTail);
      issueOne(ROB_BRANCH, 5'd0, 0, 0, 0, 32'h100);
      issueOne(ROB_REG, 5'd7, 0, 0, 0, 0);
      idle(); s.aluFlag = 1; s.aluDest = brTag; s.aluVal = 1; applyStimulus();
      issueOne(ROB_REG, 5'd6, 1, 32'h66, 0, 0);
      settle();
      check("t4 clearOut", 32'(robBus.clearOut), 32'd1);
      check("t4 clearPc", robBus.clearPc, 32'h100);
      check("t4 allocTag", 32'(robBus.allocTag), 32'd0);
      check("t4 full", 32'(robBus.full), 32'd0);
      idle(); s.issueFlag = 1; s.issueType = ROB_REG; s.issueRd = 5;
      s.aluFlag = 1; s.aluDest = 0; s.aluVal = 32'h77; applyStimulus();
      idle(); s.queryJTag = 0; applyStimulus();
      check("t4 late wb ignored", 32'(robBus.queryJReady), 32'd0);

      // Scenario 5: same-cycle bypass of an ALU result into a query.
      for (int i = 0; i < 3; i++) issueOne(ROB_REG, 5'(8 + i), 0, 0, 0, 0);
      idle(); s.queryJTag = 3; s.queryKTag = 2; s.aluFlag = 1; s.aluDest = 3; s.aluVal = 32'hAB;
      applyStimulus();
      check("t5 queryJReady", 32'(robBus.queryJReady), 32'd1);
      check("t5 queryJVal", robBus.queryJVal, 32'hAB);
      check("t5 queryKReady", 32'(robBus.queryKReady), 32'd0);

      // Scenario 6: dual writeback, then a three-cycle stall mid-retire.
      issueOne(ROB_REG, 5'd11, 0, 0, 0, 0);
      issueOne(ROB_REG, 5'd12, 0, 0, 0, 0);
      idle(); s.aluFlag = 1; s.aluDest = 4; s.aluVal = 32'h44;
      s.lsbFlag = 1; s.lsbDest = 5; s.lsbVal = 32'h55; applyStimulus();
      idle(); s.queryJTag = 4; s.queryKTag = 5; applyStimulus();
      check("t6 queryJVal", robBus.queryJVal, 32'h44);
      check("t6 queryKVal", robBus.queryKVal, 32'h55);
      idle(); s.aluFlag = 1; s.aluDest = 0; s.aluVal = 32'h10;
      s.lsbFlag = 1; s.lsbDest = 1; s.lsbVal = 32'h11; applyStimulus();
      idle(); s.aluFlag = 1; s.aluDest = 2; s.aluVal = 32'h12; applyStimulus();
      idle(); applyStimulus();
      tailSave = mTail;
      for (int i = 0; i < 3; i++) begin
         idle(); s.readyIn = 0; s.issueFlag = 1; s.aluFlag = 1; s.aluDest = 4'(i); applyStimulus();
         settle();
         check("t6 stall allocTag", 32'(robBus.allocTag), 32'(tailSave));
      end
      drain();

      // Reset in the middle of activity.
      for (int i = 0; i < 5; i++) issueOne(ROB_REG, 5'(i + 1), 1, $urandom, 0, 0);
      applyReset();

      // Random phase.
      for (int n = 0; n < 1500; n++) begin
         idle();
         s.readyIn        = ($urandom_range(9) != 0);
         s.issueFlag      = 1'($urandom_range(1));
         s.issueType      = 2'($urandom_range(2));
         s.issueRd        = 5'($urandom_range(31));
         s.issueReady     = ($urandom_range(3) == 0);
         s.issueVal       = $urandom;
         s.issuePredTaken = 1'($urandom_range(1));
         s.issueAltPc     = $urandom;
         s.queryJTag      = 4'($urandom_range(15));
         s.queryKTag      = 4'($urandom_range(15));
         if (rob.size() > 0) begin
            s.queryJTag = rob[$urandom_range(rob.size() - 1)].tag;
            if ($urandom_range(1) == 1) begin
               s.aluFlag = 1; s.aluVal = $urandom;
               s.aluDest = rob[$urandom_range(rob.size() - 1)].tag;
            end
            if ($urandom_range(2) == 0) begin
               s.lsbFlag = 1; s.lsbVal = $urandom;
               s.lsbDest = rob[$urandom_range(rob.size() - 1)].tag;
            end
         end
         applyStimulus();
      end
      @(negedge clockIn);
      checkOutput();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
